// File: rtl/o_coef_seq.sv
// Row-serial online-softmax rescale coefficient unit.
// One shared restoring divider; coef = (l_old/l_new) * 2^-(m_new-m_old).
module o_coef_seq #(
   parameter int D_W      = 8,
   parameter int TIL      = 16,
   parameter int M_FRAC   = 4,
   parameter int OUT_W    = 16,
   parameter int OUT_FRAC = 14
) (
   input  logic                      I_CLK,
   input  logic                      I_RST,
   input  logic                      I_VLD,
   output logic                      O_RDY,
   input  logic [2*D_W-1:0]          I_LI_OLD [0:TIL-1],
   input  logic [2*D_W-1:0]          I_LI_NEW [0:TIL-1],
   input  logic [D_W-1:0]            I_MI_OLD [0:TIL-1],
   input  logic [D_W-1:0]            I_MI_NEW [0:TIL-1],
   output logic                      O_VLD,
   input  logic                      I_RDY,
   output logic [OUT_W-1:0]          O_COEF,
   output logic [$clog2(TIL)-1:0]    O_ROW,
   output logic                      O_LAST,
   output logic                      O_SAT
);

   localparam int L_W  = 2 * D_W;
   localparam int R_W  = $clog2(TIL);
   localparam int E_W  = OUT_FRAC + 1;
   localparam int K_W  = D_W + 1 - M_FRAC;
   localparam int SH   = OUT_W - OUT_FRAC;
   localparam int DV_W = L_W + OUT_FRAC;
   localparam int C_W  = $clog2(OUT_W);
   localparam int P_W  = OUT_W + E_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DIV,
      S_MUL,
      S_OUT
   } state_t;

   state_t           state;
   logic [L_W-1:0]   lo_r [0:TIL-1];
   logic [L_W-1:0]   ln_r [0:TIL-1];
   logic [D_W-1:0]   mo_r [0:TIL-1];
   logic [D_W-1:0]   mn_r [0:TIL-1];
   logic [R_W-1:0]   row;
   logic [L_W-1:0]   rem;
   logic [L_W-1:0]   den;
   logic [OUT_W-1:0] dlo;
   logic [OUT_W-1:0] q;
   logic [E_W-1:0]   e_r;
   logic             sat_r;
   logic             skip;
   logic [C_W-1:0]   cnt;

   logic [L_W-1:0]    lo_s;
   logic [L_W-1:0]    ln_s;
   logic [D_W-1:0]    mo_s;
   logic [D_W-1:0]    mn_s;
   logic [D_W:0]      d_raw;
   logic [D_W:0]      d_cl;
   logic [K_W-1:0]    k;
   logic [M_FRAC-1:0] f;
   logic [E_W-1:0]    e_pre;
   logic [E_W-1:0]    e_n;
   logic [L_W+SH-1:0] ln_sh;
   logic              ovf;
   logic              zero;
   logic [DV_W-1:0]   dvd;
   logic [L_W:0]      trial;
   logic              ge;
   logic [P_W-1:0]    prod;
   logic [OUT_W:0]    p_hi;

   always_comb begin
      lo_s  = lo_r[row];
      ln_s  = ln_r[row];
      mo_s  = mo_r[row];
      mn_s  = mn_r[row];
      d_raw = {mn_s[D_W-1], mn_s} - {mo_s[D_W-1], mo_s};
      d_cl  = d_raw[D_W] ? '0 : d_raw;
      k     = d_cl[D_W:M_FRAC];
      f     = d_cl[M_FRAC-1:0];
      // linear 2^-f approximation on the fractional part
      e_pre = (E_W'(1) << OUT_FRAC)
            - (E_W'(f) << (OUT_FRAC - M_FRAC - 1));
      e_n   = (32'(k) > OUT_FRAC) ? '0 : (e_pre >> k);
      ln_sh = {ln_s, {SH{1'b0}}};
      ovf   = ({{SH{1'b0}}, lo_s} >= ln_sh);
      zero  = (ln_s == '0);
      dvd   = {lo_s, {OUT_FRAC{1'b0}}};
      trial = {rem, dlo[OUT_W-1]};
      ge    = (trial >= {1'b0, den});
      prod  = P_W'(q) * P_W'(e_r);
      p_hi  = (OUT_W+1)'(prod >> OUT_FRAC);
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state  <= S_IDLE;
         O_RDY  <= 1'b1;
         O_VLD  <= 1'b0;
         O_COEF <= '0;
         O_ROW  <= '0;
         O_LAST <= 1'b0;
         O_SAT  <= 1'b0;
         row    <= '0;
         rem    <= '0;
         den    <= '0;
         dlo    <= '0;
         q      <= '0;
         e_r    <= '0;
         sat_r  <= 1'b0;
         skip   <= 1'b0;
         cnt    <= '0;
         for (int i = 0; i < TIL; i++) begin
            lo_r[i] <= '0;
            ln_r[i] <= '0;
            mo_r[i] <= '0;
            mn_r[i] <= '0;
         end
      end else begin
         unique case (state)
            S_IDLE: begin
               if (I_VLD) begin
                  for (int i = 0; i < TIL; i++) begin
                     lo_r[i] <= I_LI_OLD[i];
                     ln_r[i] <= I_LI_NEW[i];
                     mo_r[i] <= I_MI_OLD[i];
                     mn_r[i] <= I_MI_NEW[i];
                  end
                  row   <= '0;
                  O_RDY <= 1'b0;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               e_r <= e_n;
               den <= ln_s;
               rem <= L_W'(dvd >> OUT_W);
               dlo <= dvd[OUT_W-1:0];
               cnt <= '0;
               if (zero || ovf) begin
                  sat_r <= 1'b1;
                  skip  <= 1'b1;
                  q     <= '1;
               end else begin
                  sat_r <= 1'b0;
                  skip  <= 1'b0;
                  q     <= '0;
               end
               state <= S_DIV;
            end
            S_DIV: begin
               // skipped divides still burn OUT_W cycles
               if (!skip) begin
                  dlo <= dlo << 1;
                  if (ge) begin
                     rem <= L_W'(trial - {1'b0, den});
                     q   <= {q[OUT_W-2:0], 1'b1};
                  end else begin
                     rem <= trial[L_W-1:0];
                     q   <= {q[OUT_W-2:0], 1'b0};
                  end
               end
               cnt <= cnt + C_W'(1);
               if (cnt == C_W'(OUT_W - 1)) begin
                  state <= S_MUL;
               end
            end
            S_MUL: begin
               if (p_hi[OUT_W]) begin
                  O_COEF <= '1;
                  O_SAT  <= 1'b1;
               end else begin
                  O_COEF <= p_hi[OUT_W-1:0];
                  O_SAT  <= sat_r;
               end
               O_ROW  <= row;
               O_LAST <= (row == R_W'(TIL - 1));
               O_VLD  <= 1'b1;
               state  <= S_OUT;
            end
            S_OUT: begin
               if (I_RDY) begin
                  O_VLD <= 1'b0;
                  if (O_LAST) begin
                     O_RDY <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     row   <= row + R_W'(1);
                     state <= S_LOAD;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_o_coef_seq.sv
// Directed bench for o_coef_seq (TIL=4): values, latency,
// saturation, backpressure, mid-tile reset, back-to-back tiles.
module tb_o_coef_seq;

   logic        clk;
   logic        I_RST;
   logic        I_VLD;
   logic        O_RDY;
   logic [15:0] li_old [0:3];
   logic [15:0] li_new [0:3];
   logic [7:0]  mi_old [0:3];
   logic [7:0]  mi_new [0:3];
   logic        O_VLD;
   logic        I_RDY;
   logic [15:0] O_COEF;
   logic [1:0]  O_ROW;
   logic        O_LAST;
   logic        O_SAT;

   o_coef_seq #(
      .D_W(8), .TIL(4), .M_FRAC(4), .OUT_W(16), .OUT_FRAC(14)
   ) dut (
      .I_CLK(clk),
      .I_RST(I_RST),
      .I_VLD(I_VLD),
      .O_RDY(O_RDY),
      .I_LI_OLD(li_old),
      .I_LI_NEW(li_new),
      .I_MI_OLD(mi_old),
      .I_MI_NEW(mi_new),
      .O_VLD(O_VLD),
      .I_RDY(I_RDY),
      .O_COEF(O_COEF),
      .O_ROW(O_ROW),
      .O_LAST(O_LAST),
      .O_SAT(O_SAT)
   );

   int ntest = 0;
   int nfail = 0;
   int cyc   = 0;
   int acc;
   int prev;
   int h_a;
   int stall [0:3];
   bit pulse_vld;
   int ec [0:1][0:3];
   bit es [0:1][0:3];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntest++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_row(input int r, input int lo, input int ln,
                          input int mo, input int mn);
      li_old[r] = 16'(lo);
      li_new[r] = 16'(ln);
      mi_old[r] = 8'(mo);
      mi_new[r] = 8'(mn);
   endtask

   task automatic set_exp(input int t, input int r, input int c,
                          input bit s);
      ec[t][r] = c;
      es[t][r] = s;
   endtask

   task automatic s1_data();
      for (int r = 0; r < 4; r++) begin
         set_row(r, 100, 100, 'h10, 'h10);
         set_exp(0, r, 16384, 1'b0);
      end
   endtask

   task automatic do_accept(input bit hold);
      int n;
      n = 0;
      I_VLD = 1'b1;
      while (O_RDY !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", O_RDY, 1);
      acc  = cyc + 1;
      prev = acc;
      @(negedge clk);
      if (!hold) I_VLD = 1'b0;
      chk("rdy_low_after_accept", O_RDY, 0);
   endtask

   task automatic get_row(input int t, input int r);
      int n;
      int hs;
      n = 0;
      while (O_VLD !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("vld_seen", O_VLD, 1);
      if (O_VLD !== 1'b1) return;
      chk("coef", O_COEF, ec[t][r]);
      chk("row", O_ROW, r);
      chk("last", O_LAST, (r == 3));
      chk("sat", O_SAT, es[t][r]);
      chk("rdy_vld_excl", O_RDY, 0);
      if (stall[r] > 0) begin
         I_RDY = 1'b0;
         repeat (stall[r]) begin
            if (pulse_vld) I_VLD = 1'b1;
            @(negedge clk);
            if (pulse_vld) I_VLD = 1'b0;
            chk("stall_vld", O_VLD, 1);
            chk("stall_coef", O_COEF, ec[t][r]);
            chk("stall_row", O_ROW, r);
            chk("stall_rdy", O_RDY, 0);
         end
         I_RDY = 1'b1;
      end
      hs = cyc + 1;
      chk("latency", hs - prev, 19 + stall[r]);
      prev = hs;
      @(negedge clk);
      chk("vld_drop", O_VLD, 0);
      if (r == 3) chk("rdy_back", O_RDY, 1);
   endtask

   task automatic do_rows(input int t);
      for (int r = 0; r < 4; r++) get_row(t, r);
   endtask

   initial begin
      int nv;
      I_RST = 1'b1;
      I_VLD = 1'b0;
      I_RDY = 1'b1;
      pulse_vld = 1'b0;
      for (int r = 0; r < 4; r++) begin
         stall[r] = 0;
         set_row(r, 0, 0, 0, 0);
      end
      repeat (3) @(negedge clk);
      chk("rst_rdy", O_RDY, 1);
      chk("rst_vld", O_VLD, 0);
      chk("rst_coef", O_COEF, 0);
      chk("rst_row", O_ROW, 0);
      chk("rst_last", O_LAST, 0);
      chk("rst_sat", O_SAT, 0);
      I_RST = 1'b0;
      @(negedge clk);

      // identity
      s1_data();
      do_accept(1'b0);
      do_rows(0);

      // exponent rows
      set_row(0, 100, 100, 'h00, 'h10); set_exp(0, 0, 8192, 1'b0);
      set_row(1, 100, 100, 'h10, 'h18); set_exp(0, 1, 12288, 1'b0);
      set_row(2, 50, 100, 'h00, 'h18);  set_exp(0, 2, 3072, 1'b0);
      set_row(3, 1, 1, 'h10, 'h0B);     set_exp(0, 3, 16384, 1'b0);
      do_accept(1'b0);
      do_rows(0);

      // saturation, truncation, k > OUT_FRAC
      set_row(0, 100, 0, 'h10, 'h10);   set_exp(0, 0, 'hFFFF, 1'b1);
      set_row(1, 500, 100, 'h10, 'h10); set_exp(0, 1, 'hFFFF, 1'b1);
      set_row(2, 1, 3, 'h20, 'h20);     set_exp(0, 2, 5461, 1'b0);
      set_row(3, 7, 7, 'h80, 'h7F);     set_exp(0, 3, 0, 1'b0);
      do_accept(1'b0);
      do_rows(0);

      // backpressure with ignored I_VLD pulses
      s1_data();
      stall[0] = 2; stall[1] = 7; stall[2] = 1; stall[3] = 3;
      pulse_vld = 1'b1;
      do_accept(1'b0);
      do_rows(0);
      pulse_vld = 1'b0;
      for (int r = 0; r < 4; r++) stall[r] = 0;
      nv = 0;
      repeat (25) begin
         @(negedge clk);
         if (O_VLD === 1'b1) nv++;
      end
      chk("no_extra_vld", nv, 0);

      // reset during row 2 divide
      do_accept(1'b0);
      get_row(0, 0);
      get_row(0, 1);
      repeat (5) @(negedge clk);
      I_RST = 1'b1;
      @(negedge clk);
      I_RST = 1'b0;
      chk("mid_rst_vld", O_VLD, 0);
      chk("mid_rst_rdy", O_RDY, 1);
      chk("mid_rst_coef", O_COEF, 0);
      chk("mid_rst_row", O_ROW, 0);
      nv = 0;
      repeat (40) begin
         @(negedge clk);
         if (O_VLD === 1'b1) nv++;
      end
      chk("no_vld_after_rst", nv, 0);
      do_accept(1'b0);
      do_rows(0);

      // back-to-back tiles
      set_row(0, 100, 100, 'h00, 'h10); set_exp(0, 0, 8192, 1'b0);
      set_row(1, 100, 100, 'h10, 'h18); set_exp(0, 1, 12288, 1'b0);
      set_row(2, 50, 100, 'h00, 'h18);  set_exp(0, 2, 3072, 1'b0);
      set_row(3, 100, 0, 'h10, 'h10);   set_exp(0, 3, 'hFFFF, 1'b1);
      do_accept(1'b1);
      set_row(0, 300, 100, 'h10, 'h10); set_exp(1, 0, 49152, 1'b0);
      set_row(1, 100, 100, 'h90, 'h70); set_exp(1, 1, 1, 1'b0);
      set_row(2, 9, 9, 'h00, 'h0F);     set_exp(1, 2, 8704, 1'b0);
      set_row(3, 200, 100, 'h00, 'h30); set_exp(1, 3, 4096, 1'b0);
      do_rows(0);
      h_a = prev;
      do_accept(1'b0);
      chk("b2b_gap", acc - h_a, 1);
      do_rows(1);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
